flag_unit: RTL and testbench

Status-flag and interrupt-control register block for the 8-bit MCU datapath. It receives the carry and zero outputs of the ALU and registers them as the architectural C and Z flags. It feeds the carry flag back to the ALU carry-in and evaluates branch conditions for the control unit. It also owns the interrupt-enable flag, shadow flags for interrupt entry and exit, and the interrupt request synchronizer and pending latch.

---
 rtl/flag_unit.sv | 96 +++++++++
 tb/tb_flag_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// Architectural C/Z/I flags, interrupt-entry shadow copies, and the external
// interrupt synchronizer/pending latch for the 8-bit MCU datapath.
module flag_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_c,
  input  logic       alu_z,
  input  logic       flg_c_ld,
  input  logic       flg_z_ld,
  input  logic       flg_ld_sel,
  input  logic       flg_c_set,
  input  logic       flg_c_clr,
  input  logic       flg_shad_ld,
  input  logic       i_set,
  input  logic       i_clr,
  input  logic       intr,
  input  logic       int_ack,
  input  logic [2:0] br_cond,
  output logic       c_flag,
  output logic       z_flag,
  output logic       i_flag,
  output logic       cin,
  output logic       br_taken,
  output logic       int_pend
);

  logic shad_c, shad_z;
  logic sync1, sync2, sync3;
  logic pend;
  logic c_src, z_src;
  logic intr_edge;

  assign c_src     = flg_ld_sel ? shad_c : alu_c;
  assign z_src     = flg_ld_sel ? shad_z : alu_z;
  assign intr_edge = sync2 & ~sync3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (flg_c_clr)      c_flag <= 1'b0;
      else if (flg_c_set) c_flag <= 1'b1;
      else if (flg_c_ld)  c_flag <= c_src;
      if (flg_z_ld)       z_flag <= z_src;
    end
  end

  // Shadows take the pre-edge flags, so a shadow load alongside a restore swaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shad_c <= 1'b0;
      shad_z <= 1'b0;
    end else if (flg_shad_ld || int_ack) begin
      shad_c <= c_flag;
      shad_z <= z_flag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  i_flag <= 1'b0;
    else if (int_ack || i_clr) i_flag <= 1'b0;
    else if (i_set)           i_flag <= 1'b1;
  end

  // A fresh edge wins over the acknowledge so a back-to-back request is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      pend  <= 1'b0;
    end else begin
      sync1 <= intr;
      sync2 <= sync1;
      sync3 <= sync2;
      pend  <= intr_edge | (pend & ~int_ack);
    end
  end

  assign cin      = c_flag;
  assign int_pend = pend & i_flag;

  always_comb begin
    br_taken = 1'b0;
    unique case (br_cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = c_flag;
      3'b010:  br_taken = ~c_flag;
      3'b011:  br_taken = z_flag;
      3'b100:  br_taken = ~z_flag;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: vector tables for flag loads and branch decode,
// hand-written sequences for the interrupt, shadow and reset corner cases.
module tb_flag_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_c, alu_z, flg_c_ld, flg_z_ld, flg_ld_sel, flg_c_set, flg_c_clr;
  logic       flg_shad_ld, i_set, i_clr, intr, int_ack;
  logic [2:0] br_cond;
  logic       c_flag, z_flag, i_flag, cin, br_taken, int_pend;

  int checks = 0;
  int errors = 0;

  flag_unit dut (
    .clk(clk), .rst(rst), .alu_c(alu_c), .alu_z(alu_z),
    .flg_c_ld(flg_c_ld), .flg_z_ld(flg_z_ld), .flg_ld_sel(flg_ld_sel),
    .flg_c_set(flg_c_set), .flg_c_clr(flg_c_clr), .flg_shad_ld(flg_shad_ld),
    .i_set(i_set), .i_clr(i_clr), .intr(intr), .int_ack(int_ack),
    .br_cond(br_cond), .c_flag(c_flag), .z_flag(z_flag), .i_flag(i_flag),
    .cin(cin), .br_taken(br_taken), .int_pend(int_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr, set, ld, ac, zld, az;
    logic exp_c, exp_z;
  } ld_vec_t;

  typedef struct {
    logic       c, z;
    logic [7:0] taken_mask;
  } br_vec_t;

  ld_vec_t ld_tab [6];
  br_vec_t br_tab [4];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_c = 0; alu_z = 0; flg_c_ld = 0; flg_z_ld = 0; flg_ld_sel = 0;
    flg_c_set = 0; flg_c_clr = 0; flg_shad_ld = 0; i_set = 0; i_clr = 0;
    int_ack = 0; br_cond = 3'b000;
  endtask

  task automatic alu_write(input logic c, input logic z);
    alu_c = c; alu_z = z; flg_c_ld = 1; flg_z_ld = 1;
    step();
    flg_c_ld = 0; flg_z_ld = 0;
  endtask

  initial begin
    //            clr set ld  ac  zld az  c   z
    ld_tab[0] = '{0,  0,  1,  1,  1,  1,  1,  1};
    ld_tab[1] = '{1,  1,  1,  1,  0,  0,  0,  1};
    ld_tab[2] = '{0,  1,  1,  0,  1,  0,  1,  0};
    ld_tab[3] = '{0,  0,  0,  0,  0,  1,  1,  0};
    ld_tab[4] = '{0,  0,  1,  0,  1,  1,  0,  1};
    ld_tab[5] = '{1,  0,  0,  0,  0,  0,  0,  1};
    // bit n of taken_mask is the expected BR_TAKEN for br_cond = n
    br_tab[0] = '{0, 0, 8'b0001_0101};
    br_tab[1] = '{0, 1, 8'b0000_1101};
    br_tab[2] = '{1, 0, 8'b0001_0011};
    br_tab[3] = '{1, 1, 8'b0000_1011};

    // reset with every load active and the request line high
    idle_inputs();
    rst = 1; intr = 1;
    alu_c = 1; alu_z = 1; flg_c_ld = 1; flg_z_ld = 1; flg_c_set = 1;
    flg_shad_ld = 1; i_set = 1;
    #2;
    repeat (3) step();
    chk("rst_c", c_flag, 0);
    chk("rst_z", z_flag, 0);
    chk("rst_i", i_flag, 0);
    chk("rst_cin", cin, 0);
    chk("rst_int_pend", int_pend, 0);
    chk("rst_br_always", br_taken, 1);
    br_cond = 3'b001; #1;
    chk("rst_br_cs", br_taken, 0);
    idle_inputs();
    rst = 0;
    repeat (4) step();
    chk("post_rst_int_pend_masked", int_pend, 0);
    chk("post_rst_i", i_flag, 0);
    intr = 0; rst = 1; #2; rst = 0;
    step();

    // flag load priority table
    foreach (ld_tab[k]) begin
      flg_c_clr = ld_tab[k].clr; flg_c_set = ld_tab[k].set;
      flg_c_ld = ld_tab[k].ld; alu_c = ld_tab[k].ac;
      flg_z_ld = ld_tab[k].zld; alu_z = ld_tab[k].az;
      step();
      idle_inputs();
      chk($sformatf("ld%0d_c", k), c_flag, ld_tab[k].exp_c);
      chk($sformatf("ld%0d_cin", k), cin, ld_tab[k].exp_c);
      chk($sformatf("ld%0d_z", k), z_flag, ld_tab[k].exp_z);
    end

    // branch decode sweep
    foreach (br_tab[k]) begin
      alu_write(br_tab[k].c, br_tab[k].z);
      chk($sformatf("br%0d_c", k), c_flag, br_tab[k].c);
      chk($sformatf("br%0d_z", k), z_flag, br_tab[k].z);
      for (int b = 0; b < 8; b++) begin
        br_cond = 3'(b);
        #1;
        chk($sformatf("br_c%0b_z%0b_cond%0d", br_tab[k].c, br_tab[k].z, b),
            br_taken, br_tab[k].taken_mask[b]);
      end
      br_cond = 3'b000;
    end

    // interrupt entry and RETIE
    alu_write(1, 0);
    i_set = 1; step(); i_set = 0;
    chk("irq_i_set", i_flag, 1);
    repeat (4) step();
    intr = 1;
    step(); chk("irq_edge5", int_pend, 0);
    step(); chk("irq_edge6", int_pend, 0);
    step(); chk("irq_edge7", int_pend, 1);
    repeat (3) step();
    chk("irq_held", int_pend, 1);
    int_ack = 1; step(); int_ack = 0;
    chk("ack_i", i_flag, 0);
    chk("ack_int_pend", int_pend, 0);
    chk("ack_c_kept", c_flag, 1);
    repeat (3) step();
    alu_write(0, 1);
    chk("isr_c", c_flag, 0);
    chk("isr_z", z_flag, 1);
    flg_ld_sel = 1; flg_c_ld = 1; flg_z_ld = 1; i_set = 1;
    step();
    idle_inputs();
    chk("retie_c", c_flag, 1);
    chk("retie_z", z_flag, 0);
    chk("retie_i", i_flag, 1);
    chk("retie_single_event", int_pend, 0);
    intr = 0;
    repeat (3) step();

    // masked request stays latched
    i_clr = 1; step(); i_clr = 0;
    chk("mask_i", i_flag, 0);
    intr = 1; repeat (3) step();
    intr = 0; repeat (3) step();
    chk("mask_int_pend", int_pend, 0);
    i_set = 1; step(); i_set = 0;
    chk("unmask_i", i_flag, 1);
    chk("unmask_int_pend", int_pend, 1);
    int_ack = 1; step(); int_ack = 0;
    chk("mask_ack_i", i_flag, 0);
    chk("mask_ack_int_pend", int_pend, 0);
    repeat (3) step();

    // ack coinciding with a newly detected edge
    intr = 1;
    step(); step();
    int_ack = 1; step(); int_ack = 0;
    chk("sim_ack_i", i_flag, 0);
    i_set = 1; step(); i_set = 0;
    chk("sim_pend_kept", int_pend, 1);
    int_ack = 1; i_set = 1; step(); int_ack = 0; i_set = 0;
    chk("ack_beats_set", i_flag, 0);
    i_set = 1; step(); i_set = 0;
    chk("sim_pend_cleared", int_pend, 0);
    intr = 0;
    repeat (3) step();

    // shadow load and restore on the same edge swap cleanly
    alu_write(1, 1);
    flg_shad_ld = 1; step(); flg_shad_ld = 0;
    alu_write(0, 0);
    flg_shad_ld = 1; flg_ld_sel = 1; flg_c_ld = 1; flg_z_ld = 1;
    step();
    chk("swap1_c", c_flag, 1);
    chk("swap1_z", z_flag, 1);
    flg_shad_ld = 0;
    step();
    idle_inputs();
    chk("swap2_c", c_flag, 0);
    chk("swap2_z", z_flag, 0);

    // asynchronous reset mid-request
    alu_write(1, 0);
    chk("pre_rst_i", i_flag, 1);
    intr = 1;
    step(); step();
    #2; rst = 1; #1;
    chk("async_rst_i", i_flag, 0);
    chk("async_rst_c", c_flag, 0);
    chk("async_rst_int_pend", int_pend, 0);
    intr = 0;
    #2; rst = 0;
    repeat (3) step();
    i_set = 1; step(); i_set = 0;
    chk("lost_request", int_pend, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
